sci_tx_serializer: RTL

SCI (UART) transmitter that turns the 68HC05-side byte stream into an asynchronous serial line with 68HC05 SCI framing.
- Framing: start bit, 8 data bits LSB first, optional 9th bit, stop bit.
- Sits between the microcontroller's SCI data-register write path and the board-level TXD pin.
- Provides a one-entry transmit data register (TDR) plus shift register, and TDRE/TC status matching the SCSR semantics.

---
 rtl/sci_pkg.sv | 17 +
 rtl/sci_baud_gen.sv | 43 ++++
 rtl/sci_tx_serializer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sci_pkg.sv
// Shared SCI definitions: transmitter state encoding and frame constants.
package sci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    NINTH,
    STOP,
    BREAK
  } sci_tx_state_t;

  localparam int SCI_DATA_BITS    = 8;
  localparam int SCI_BREAK_BITS_8 = 10;
  localparam int SCI_BREAK_BITS_9 = 11;

endpackage

// File: rtl/sci_baud_gen.sv
// Bit-period generator: a down-counter reloaded from the divisor captured at frame_load.
// OVERSAMPLE > 1 gives the receiver's sub-bit ticks; bit_end fires every OVERSAMPLE periods.
module sci_baud_gen #(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 1
) (
  input  logic             clk30,
  input  logic             reset_n,
  input  logic             en,
  input  logic             frame_load,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] cnt;
  logic [SUB_W-1:0] sub;
  logic             tick;

  assign tick    = en && (cnt == '0);
  assign bit_end = tick && (sub == SUB_W'(OVERSAMPLE - 1));

  // frame_load wins over a coincident tick so a back-to-back frame starts on the new divisor.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      div_lat <= '0;
      cnt     <= '0;
      sub     <= '0;
    end else if (frame_load) begin
      div_lat <= div;
      cnt     <= div;
      sub     <= '0;
    end else if (tick) begin
      cnt <= div_lat;
      sub <= bit_end ? '0 : sub + 1'b1;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sci_tx_serializer.sv
// SCI transmitter: one-entry TDR feeding a shifter, 68HC05 framing (start, 8/9 data, stop) and break.
module sci_tx_serializer
  import sci_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk30,
  input  logic             reset_n,
  input  logic             te,
  input  logic             sbk,
  input  logic             m9,
  input  logic             t8,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [7:0]       in_data,
  input  logic             in_write,
  input  logic             ovr_clr,
  output logic             txd,
  output logic             tdre,
  output logic             tc,
  output logic             ovr,
  output logic             busy
);

  sci_tx_state_t state;
  logic [7:0]    tdr;
  logic          tdr_t8;
  logic [7:0]    shifter;
  logic          sh_t8;
  logic          m9_lat;
  logic [3:0]    bit_cnt;

  logic bit_end;
  logic running;
  logic may_start;
  logic break_last;
  logic load_now;
  logic break_now;
  logic frame_load;
  logic write_ok;
  logic write_ovf;

  assign running    = (state != IDLE);
  assign may_start  = (state == IDLE) || ((state == STOP) && bit_end);
  assign break_last = (state == BREAK) && bit_end &&
                      (bit_cnt == (m9_lat ? 4'(SCI_BREAK_BITS_9 - 1) : 4'(SCI_BREAK_BITS_8 - 1)));
  assign break_now  = te && sbk && (may_start || break_last);
  assign load_now   = te && !sbk && !tdre && may_start;
  assign frame_load = load_now || break_now;

  // Write handshake: in_write is taken when tdre=1 or the TDR is moved to the shifter in
  // that same cycle; otherwise the byte is dropped and ovr is set (set beats ovr_clr).
  assign write_ok  = in_write && (tdre || load_now);
  assign write_ovf = in_write && !write_ok;

  sci_baud_gen #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (1)
  ) u_baud (
    .clk30      (clk30),
    .reset_n    (reset_n),
    .en         (running),
    .frame_load (frame_load),
    .div        (baud_div),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      tdre    <= 1'b1;
      tc      <= 1'b1;
      ovr     <= 1'b0;
      busy    <= 1'b0;
      tdr     <= '0;
      tdr_t8  <= 1'b0;
      shifter <= '0;
      sh_t8   <= 1'b0;
      m9_lat  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (write_ok) begin
        tdr    <= in_data;
        tdr_t8 <= t8;
      end

      if (load_now)      tdre <= !in_write;
      else if (write_ok) tdre <= 1'b0;

      if (write_ovf)    ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;

      if (load_now) begin
        state   <= START;
        txd     <= 1'b0;
        shifter <= tdr;
        sh_t8   <= tdr_t8;
        m9_lat  <= m9;
        bit_cnt <= '0;
        tc      <= 1'b0;
        busy    <= 1'b1;
      end else if (break_now) begin
        state   <= BREAK;
        txd     <= 1'b0;
        m9_lat  <= m9;
        bit_cnt <= '0;
        tc      <= 1'b0;
        busy    <= 1'b1;
      end else if (bit_end) begin
        case (state)
          START: begin
            state   <= DATA;
            txd     <= shifter[0];
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == 4'(SCI_DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (m9_lat) begin
                state <= NINTH;
                txd   <= sh_t8;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              shifter <= shifter >> 1;
              txd     <= shifter[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          NINTH: begin
            state <= STOP;
            txd   <= 1'b1;
          end
          STOP: begin
            state <= IDLE;
            txd   <= 1'b1;
            tc    <= 1'b1;
            busy  <= 1'b0;
          end
          BREAK: begin
            if (break_last) begin
              state   <= STOP;
              txd     <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
